mem_arbiter: RTL and testbench

Shares the single multi-cycle main memory between the instruction-cache and data-cache miss handlers. Each requester holds a level request; the arbiter grants one at a time, then either streams an 8-word block fill (pipelined reads) or performs a single-word write. It sits between both cache controllers and the memory model, and its busy time is what the caches turn into their stall outputs.

---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache and
// D-cache miss handlers. One owner at a time; a grant either streams an
// 8-word block fill (issue side and return side counted independently) or
// performs a single-word write. The outputs are Moore-style on the memory
// side, and the return data passes straight through to the owner.

// Per-requester response stage. It steers fill returns and completion
// pulses to one side. A side that does not own the transaction sees all
// zeros.
module mem_arbiter_port #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 3
) (
  input  logic              own,
  input  logic              ret,
  input  logic              ret_last,
  input  logic              wr_cyc,
  input  logic [DATA_W-1:0] rdata,
  input  logic [CNT_W-1:0]  idx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [CNT_W-1:0]  word,
  output logic              done
);

  // Gate the shared return path with ownership; done fires on the last fill word or on the write cycle.
  always_comb begin
    valid = own & ret;
    data  = valid ? rdata : '0;
    word  = valid ? idx : '0;
    done  = own & ((ret & ret_last) | wr_cyc);
  end

endmodule

module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_valid,
  output logic [2:0]  i_word,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_data,
  output logic        d_valid,
  output logic [2:0]  d_word,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int CNT_W   = $clog2(WORDS_PER_BLOCK);
  localparam int NUM_REQ = 2;
  localparam int I_IDX   = 0;
  localparam int D_IDX   = 1;
  localparam logic OWN_I = 1'b0;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  // The word counters are sized by the block length, so the block length must be a power of two.
  // The arbiter counts returns rather than cycles, so the latency only has to be at least one cycle.
  if (WORDS_PER_BLOCK != (1 << CNT_W) || MEM_LATENCY < 1) begin : g_param_check
    $error("mem_arbiter: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Transaction context captured at grant; later changes on the request pins are ignored.
  typedef struct packed {
    logic        owner;   // 0 = I, 1 = D
    logic [15:0] base;    // block base (low nibble cleared)
    logic [15:0] waddr;   // halfword-aligned write address
    logic [15:0] wdata;
  } txn_t;

  state_t            state, state_nxt;
  txn_t              txn;
  logic              last_owner;
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue_end;
  logic [CNT_W-1:0]  recv_cnt;
  logic              gnt_i, gnt_d, grant;
  logic              ret, ret_last;

  logic [NUM_REQ-1:0]            side_own;
  logic [NUM_REQ-1:0][15:0]      side_data;
  logic [NUM_REQ-1:0]            side_valid;
  logic [NUM_REQ-1:0][CNT_W-1:0] side_word;
  logic [NUM_REQ-1:0]            side_done;

  // Grant selection: a lone request wins; under contention, the side not served last wins.
  always_comb begin
    gnt_d = d_req & (~i_req | (last_owner == OWN_I));
    gnt_i = i_req & ~gnt_d;
    grant = (state == IDLE) & (gnt_i | gnt_d);
  end

  // Fill returns only count while filling; stray mem_valid elsewhere is dropped.
  always_comb begin
    ret      = (state == FILL) & mem_valid;
    ret_last = (recv_cnt == LAST_WORD);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_d)      state_nxt = d_wr ? WRITE : FILL;
        else if (gnt_i) state_nxt = FILL;
      end
      FILL:    if (ret && ret_last) state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Latch the grant context and run the independent issue and return counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn        <= '0;
      last_owner <= OWN_I;
      issue_cnt  <= '0;
      issue_end  <= 1'b0;
      recv_cnt   <= '0;
    end else if (grant) begin
      txn.owner  <= gnt_d;
      txn.base   <= (gnt_d ? d_addr : i_addr) & 16'hFFF0;
      txn.waddr  <= d_addr & 16'hFFFE;
      txn.wdata  <= d_wdata;
      last_owner <= gnt_d;
      issue_cnt  <= '0;
      issue_end  <= 1'b0;
      recv_cnt   <= '0;
    end else if (state == FILL) begin
      if (!issue_end) begin
        if (issue_cnt == LAST_WORD) issue_end <= 1'b1;
        else                        issue_cnt <= issue_cnt + 1'b1;
      end
      if (mem_valid) recv_cnt <= recv_cnt + 1'b1;
    end
  end

  // Memory-side outputs: these are driven by the state alone, so reset clears them at once.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      FILL: begin
        if (!issue_end) begin
          mem_en   = 1'b1;
          mem_addr = txn.base + 16'({issue_cnt, 1'b0});
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = txn.waddr;
        mem_wdata = txn.wdata;
      end
      default: ;
    endcase
  end

  // One response stage per requester, indexed by owner id.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_port
    assign side_own[r] = (state != IDLE) & (txn.owner == 1'(r));

    mem_arbiter_port #(.DATA_W(16), .CNT_W(CNT_W)) u_port (
      .own      (side_own[r]),
      .ret      (ret),
      .ret_last (ret_last),
      .wr_cyc   (state == WRITE),
      .rdata    (mem_rdata),
      .idx      (recv_cnt),
      .data     (side_data[r]),
      .valid    (side_valid[r]),
      .word     (side_word[r]),
      .done     (side_done[r])
    );
  end

  assign i_data  = side_data[I_IDX];
  assign i_valid = side_valid[I_IDX];
  assign i_word  = side_word[I_IDX];
  assign i_done  = side_done[I_IDX];
  assign d_data  = side_data[D_IDX];
  assign d_valid = side_valid[D_IDX];
  assign d_word  = side_word[D_IDX];
  assign d_done  = side_done[D_IDX];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A latency/gap-configurable memory model serves
// the DUT. The expected return schedule and data come from arithmetic on
// the issue times, the latency and the gap, plus a bench-side shadow of
// every intended write.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, d_wr, mem_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] i_data, d_data, mem_addr, mem_wdata;
  logic        i_valid, i_done, d_valid, d_done, mem_en, mem_wr;
  logic [2:0]  i_word, d_word;

  int n_tests = 0;
  int n_fail  = 0;

  int mem_lat = 4;
  int mem_gap = 0;
  bit stray   = 0;

  logic [15:0] mstore [logic [15:0]];   // memory model contents (written from DUT port)
  logic [15:0] rstore [logic [15:0]];   // reference contents (written from intent)

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
    .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data(d_data), .d_valid(d_valid), .d_word(d_word), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_word(logic [15:0] a);
    if (mstore.exists(a)) return mstore[a];
    return init_word(a);
  endfunction

  function automatic logic [15:0] ref_word(logic [15:0] a);
    if (rstore.exists(a)) return rstore[a];
    return init_word(a);
  endfunction

  // Memory model: reads return in order, no earlier than mem_lat cycles after
  // issue and at least mem_gap idle cycles apart.
  logic [15:0] q_addr[$];
  int          q_cyc[$];
  initial begin
    int cyc;
    int last_ret;
    cyc = 0;
    last_ret = -100;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
      if (!rst) begin
        q_addr.delete();
        q_cyc.delete();
      end else if (stray) begin
        mem_valid = 1'b1;
      end else if (q_addr.size() > 0 && cyc >= q_cyc[0] + mem_lat &&
                   cyc >= last_ret + 1 + mem_gap) begin
        mem_valid = 1'b1;
        mem_rdata = mem_word(q_addr.pop_front());
        void'(q_cyc.pop_front());
        last_ret = cyc;
      end
      @(negedge clk);
      if (rst && mem_en) begin
        if (mem_wr) mstore[mem_addr] = mem_wdata;
        else begin
          q_addr.push_back(mem_addr);
          q_cyc.push_back(cyc);
        end
      end
    end
  end

  // Drives one block fill for a side (0 = I, 1 = D) and checks every cycle
  // up to done. The task starts and ends on a negedge in an idle cycle.
  // other_at > 0 raises the opposite request in that cycle.
  task automatic run_fill(input bit side, input logic [15:0] addr, input int lat,
                          input int gap, input int other_at, input string tag);
    int r[8];
    logic [15:0] base;
    logic [17:0] e_mem, a_mem;
    logic [20:0] e_own, a_own;
    logic [1:0]  a_oth;
    bit          ev;
    int          jj;
    mem_lat = lat;
    mem_gap = gap;
    base = addr & 16'hFFF0;
    r[0] = 1 + lat;
    for (int j = 1; j < 8; j++)
      r[j] = (j + 1 + lat > r[j-1] + 1 + gap) ? j + 1 + lat : r[j-1] + 1 + gap;
    if (side) begin
      d_addr = addr; d_wr = 1'b0; d_wdata = 16'($urandom); d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    for (int k = 1; k <= r[7]; k++) begin
      @(negedge clk);
      if (other_at == k) begin
        if (side) i_req = 1'b1;
        else      d_req = 1'b1;
      end
      if (side && k == 1) begin
        d_wr = 1'b1;
        d_wdata = 16'($urandom);
      end
      n_tests++;
      e_mem = (k <= 8) ? {1'b1, 1'b0, base + 16'(2 * (k - 1))} : 18'h0;
      a_mem = {mem_en, mem_wr, mem_en ? mem_addr : 16'h0};
      if (a_mem !== e_mem) begin
        n_fail++;
        $display("FAIL %s issue k=%0d: got en/wr/addr %h, expected %h", tag, k, a_mem, e_mem);
      end
      ev = 1'b0;
      jj = 0;
      for (int j = 0; j < 8; j++) if (r[j] == k) begin ev = 1'b1; jj = j; end
      e_own = {ev, ev ? 3'(jj) : 3'h0, ev ? ref_word(base + 16'(2 * jj)) : 16'h0, ev && jj == 7};
      if (side) a_own = {d_valid, d_valid ? d_word : 3'h0, d_valid ? d_data : 16'h0, d_done};
      else      a_own = {i_valid, i_valid ? i_word : 3'h0, i_valid ? i_data : 16'h0, i_done};
      n_tests++;
      if (a_own !== e_own) begin
        n_fail++;
        $display("FAIL %s return k=%0d: got v/word/data/done %h, expected %h", tag, k, a_own, e_own);
      end
      a_oth = side ? {i_valid, i_done} : {d_valid, d_done};
      n_tests++;
      if (a_oth !== 2'b00) begin
        n_fail++;
        $display("FAIL %s non-owner k=%0d: got valid/done %b, expected 00", tag, k, a_oth);
      end
    end
    if (side) d_req = 1'b0;
    else      i_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_en, i_valid, i_done, d_valid, d_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s idle-after: got en/iv/id/dv/dd %b, expected 00000", tag,
               {mem_en, i_valid, i_done, d_valid, d_done});
    end
  endtask

  // Single-word D write; checks the write cycle and the idle cycle after it.
  task automatic run_write(input logic [15:0] addr, input logic [15:0] data, input string tag);
    logic [37:0] e_w, a_w;
    d_addr = addr; d_wdata = data; d_wr = 1'b1; d_req = 1'b1;
    @(negedge clk);
    rstore[addr & 16'hFFFE] = data;
    e_w = {1'b1, 1'b1, addr & 16'hFFFE, data, 1'b1, 1'b0, 1'b0, 1'b0};
    a_w = {mem_en, mem_wr, mem_addr, mem_wdata, d_done, d_valid, i_valid, i_done};
    n_tests++;
    if (a_w !== e_w) begin
      n_fail++;
      $display("FAIL %s write: got en/wr/addr/wdata/dd/dv/iv/id %h, expected %h", tag, a_w, e_w);
    end
    d_req = 1'b0;
    d_wdata = ~data;
    @(negedge clk);
    n_tests++;
    if ({mem_en, d_done, i_done} !== 3'b0) begin
      n_fail++;
      $display("FAIL %s idle-after: got en/dd/id %b, expected 000", tag, {mem_en, d_done, i_done});
    end
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, i_data, i_valid, i_word, i_done,
         d_data, d_valid, d_word, d_done} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs not all zero (en=%b wr=%b addr=%h iv=%b dv=%b)",
               mem_en, mem_wr, mem_addr, i_valid, d_valid);
    end
    rst = 1'b1;
  endtask

  task automatic test_i_fill();
    run_fill(1'b0, 16'h0136, 4, 0, 0, "i_fill");
  endtask

  task automatic test_reset_mid_fill();
    mem_lat = 4; mem_gap = 0;
    i_addr = 16'h4A7C; i_req = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h4A74}) begin
      n_fail++;
      $display("FAIL rst_mid 3rd issue: got en/addr %h, expected 14a74", {mem_en, mem_addr});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, i_data, i_valid, i_word, i_done,
         d_data, d_valid, d_word, d_done} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: outputs not zero (en=%b addr=%h iv=%b id=%b)",
               mem_en, mem_addr, i_valid, i_done);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({i_valid, i_done, mem_en} !== 3'b0) begin
        n_fail++;
        $display("FAIL rst_mid held: got iv/id/en %b, expected 000", {i_valid, i_done, mem_en});
      end
    end
    rst = 1'b1;
    run_fill(1'b0, 16'h4A7C, 4, 0, 0, "rst_refill");
  endtask

  task automatic test_contention();
    do_reset();
    i_addr = 16'h7E40; i_req = 1'b1;
    run_write(16'h2005, 16'hBEEF, "contend_d1");
    d_req = 1'b1; d_addr = 16'h1230; d_wr = 1'b1;
    run_fill(1'b0, 16'h7E40, 4, 0, 0, "contend_i");
    run_write(16'h1233, 16'h0F0F, "contend_d2");
  endtask

  task automatic test_back_to_back();
    run_fill(1'b1, 16'($urandom), 4, 0, 5, "b2b_d");
    run_fill(1'b0, 16'($urandom), 3, 0, 0, "b2b_i");
  endtask

  task automatic test_irregular();
    run_fill(1'b0, 16'($urandom), 4, 2, 0, "gap_i");
    run_fill(1'b1, 16'($urandom), 2, 1, 0, "gap_d");
  endtask

  task automatic test_stray();
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({i_valid, i_done, d_valid, d_done, mem_en} !== 5'b0) begin
        n_fail++;
        $display("FAIL stray: got iv/id/dv/dd/en %b, expected 00000",
                 {i_valid, i_done, d_valid, d_done, mem_en});
      end
    end
    stray = 1'b0;
    @(negedge clk);
    run_fill(1'b1, 16'($urandom), 4, 0, 0, "after_stray");
  endtask

  task automatic test_write_readback();
    logic [15:0] a;
    a = 16'($urandom);
    run_write(a, 16'($urandom), "wb_write");
    run_fill(1'b0, a, 2, 0, 0, "wb_fill");
  endtask

  task automatic test_random();
    repeat (10) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 2) run_write(16'($urandom), 16'($urandom), "rnd_write");
      else run_fill(op[0], 16'($urandom), $urandom_range(1, 5), $urandom_range(0, 2), 0, "rnd_fill");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #2 rst = 1'b0;
    test_reset();
    test_i_fill();
    test_reset_mid_fill();
    test_contention();
    test_back_to_back();
    test_irregular();
    test_stray();
    test_write_readback();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
